// File: rtl/alu_exec_pipe.sv
// Two-stage execute ALU: S1 latches opcode/operands, S2 latches result and flags, valid/ready on both sides.
// Optional signed-overflow flag and the ovf port are built only when ALU_OVF_EN is defined.
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  alu_op = a + b;
      3'b001:  alu_op = a - b;
      3'b010:  alu_op = a & b;
      3'b011:  alu_op = a | b;
      3'b100:  alu_op = {{(WIDTH-1){1'b0}}, (sa < sb)};
      3'b101:  alu_op = {{(WIDTH-1){1'b0}}, (a < b)};
      3'b110:  alu_op = a ^ b;
      3'b111:  alu_op = ~(a | b);
      default: alu_op = '0;
    endcase
  endfunction

`ifdef ALU_OVF_EN
  function automatic logic ovf_calc(input logic [2:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] r);
    case (op)
      3'b000:  ovf_calc = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      3'b001:  ovf_calc = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  endfunction
`endif

  logic             vld_p1;
  logic [2:0]       opcode_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] alu_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] result_p2;
  logic             zero_p2;
  logic             adv1;
  logic             adv2;

  // Each stage advances when it is empty or its successor moves, so a full pipe drains and refills in one cycle.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  // ---- S1: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        opcode_p1 <= opcode;
        a_p1      <= src_a;
        b_p1      <= src_b;
      end
    end
  end

  assign alu_p1 = alu_op(opcode_p1, a_p1, b_p1);

`ifdef ALU_OVF_EN
  logic ovf_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p2 <= 1'b0;
    end else if (adv2 && vld_p1) begin
      ovf_p2 <= ovf_calc(opcode_p1, a_p1, b_p1, alu_p1);
    end
  end

  assign ovf = ovf_p2;
`endif

  // ---- S2: result and flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      zero_p2   <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= alu_p1;
        zero_p2   <= (alu_p1 == '0);
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign zero      = zero_p2;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe: directed opcode/backpressure/reset cases plus randomized traffic.
// Build with ALU_OVF_EN defined to also exercise the overflow flag.
module tb_alu_exec_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  alu_exec_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
`ifdef ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  bit   chk_ovf_dir = 1'b0;
  logic exp_ovf_dir = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic; overflow = exact signed result out of 32-bit range.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sd2147483648;
    s   = 0;
    e.ovf = 1'b0;
    case (op)
      3'd0: begin e.res = a + b; s = sa + sb; e.ovf = (s >= lim) || (s < -lim); end
      3'd1: begin e.res = a - b; s = sa - sb; e.ovf = (s >= lim) || (s < -lim); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: e.res = (a < b) ? 32'd1 : 32'd0;
      3'd6: e.res = a ^ b;
      default: e.res = ~(a | b);
    endcase
    e.zero = (e.res == 0);
    e.t    = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stimulus-side capture: every accepted input pushes its expected response.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e   = model(opcode, src_a, src_b);
      e.t = cyc;
      q.push_back(e);
      n_acc++;
    end
  end

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("result", 64'(result), 64'(q[0].res));
        chk("zero", 64'(zero), 64'(q[0].zero));
`ifdef ALU_OVF_EN
        chk("ovf", 64'(ovf), 64'(q[0].ovf));
`endif
        if (out_ready) begin
          if (lat_chk) chk("latency", 64'(cyc - q[0].t), 64'd2);
          void'(q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input string nm);
    bit got;
    opcode = op; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        chk({nm, "_res"}, 64'(result), 64'(er));
        chk({nm, "_zero"}, 64'(zero), 64'(ez));
`ifdef ALU_OVF_EN
        if (chk_ovf_dir) chk({nm, "_ovf"}, 64'(ovf), 64'(exp_ovf_dir));
`endif
      end
    end
    if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk({nm, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base, obase;
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Opcode sweep with latency check
    lat_chk = 1'b1;
    issue(3'b000, 32'h7, 32'h3, 32'h0000_000A, 1'b0, "add");
    issue(3'b001, 32'h7, 32'h3, 32'h0000_0004, 1'b0, "sub");
    issue(3'b010, 32'h7, 32'h3, 32'h0000_0003, 1'b0, "and");
    issue(3'b011, 32'h7, 32'h3, 32'h0000_0007, 1'b0, "or");
    issue(3'b110, 32'h7, 32'h3, 32'h0000_0004, 1'b0, "xor");
    issue(3'b111, 32'h7, 32'h3, 32'hFFFF_FFF8, 1'b0, "nor");
    issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, "slt");
    issue(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, "sltu");
    issue(3'b001, 32'h5, 32'h5, 32'h0, 1'b1, "sub_zero");
`ifdef ALU_OVF_EN
    chk_ovf_dir = 1'b1;
    exp_ovf_dir = 1'b1;
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, "ovf_add");
    issue(3'b001, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, "ovf_sub");
    exp_ovf_dir = 1'b0;
    issue(3'b010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, "ovf_and");
    chk_ovf_dir = 1'b0;
`endif
    drain("sweep");

    // Backpressure: 4 ADDs with out_ready low for 5 cycles
    lat_chk   = 1'b0;
    base      = n_acc;
    obase     = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode = 3'b000; src_a = $urandom; src_b = $urandom;
      in_valid = (n_acc - base) < 4;
      step();
    end
    @(negedge clk);
    chk("bp_accepts", 64'(n_acc - base), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (n_acc - base) < 4; i++) begin
      step();
      opcode = 3'b000; src_a = $urandom; src_b = $urandom;
      in_valid = (n_acc - base) < 4;
    end
    drain("bp");
    chk("bp_outputs", 64'(n_out - obase), 64'd4);

    // Full throughput: 16 back-to-back ops, one result per cycle
    lat_chk   = 1'b1;
    base      = n_acc;
    obase     = n_out;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      opcode = 3'($urandom); src_a = $urandom; src_b = $urandom;
      step();
    end
    in_valid = 1'b0;
    chk("tp_accepts", 64'(n_acc - base), 64'd16);
    drain("tp");
    chk("tp_outputs", 64'(n_out - obase), 64'd16);
    lat_chk = 1'b0;

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode = 3'b011; src_a = 32'h1234; src_b = 32'h8;
    repeat (3) step();
    @(negedge clk);
    chk("full_before_rst", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      step();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      opcode    = 3'($urandom);
      src_a     = ($urandom % 8 == 0) ? 32'h7FFF_FFFF : $urandom;
      case ($urandom % 5)
        0: src_b = src_a;
        1: src_b = 32'h8000_0000;
        default: src_b = $urandom;
      endcase
    end
    step();
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
